// File: rtl/instr_loader.sv
// ----------------------------------------------------------------------------
// instr_loader
//
// Program loader on the writing end of the instruction fetch path. It takes a
// byte stream over a valid/ready handshake and assembles 9-bit machine words.
// Each word is written into the instruction RAM. When the load is complete the
// loader releases the CPU.
//
// Stream format: N[7:0], N[15:8], then N words. Each word is sent as a lo byte
// (word[7:0]) followed by a hi byte, of which only bit 0 (word[8]) is used.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   in_valid   byte source presents in_data
//   in_data    stream byte
//   in_ready   loader accepts a byte this cycle (registered)
//   wr_en      instr RAM write strobe, one cycle per word
//   wr_addr    instr RAM write address
//   wr_data    machine word to write
//   cpu_hold   1 = hold CPU in reset, 0 = run
//   load_done  sticky: every word of the program has been written
//   err        sticky: the length header exceeded the RAM size
// ----------------------------------------------------------------------------
module instr_loader #(
    parameter int D = 10,   // instruction address width
    parameter int W = 9     // machine word width (ISA-fixed, 9 bits)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         wr_en,
    output logic [D-1:0] wr_addr,
    output logic [W-1:0] wr_data,
    output logic         cpu_hold,
    output logic         load_done,
    output logic         err
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        WORD_LO,
        WORD_HI,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t         state_reg;
    state_t         state_next;

    logic           in_ready_reg;
    logic           wr_en_reg;
    logic [D-1:0]   wr_addr_reg;
    logic [W-1:0]   wr_data_reg;
    logic           cpu_hold_reg;
    logic           load_done_reg;
    logic           err_reg;

    logic [7:0]     n_lo_reg;   // first header byte, held until the second arrives
    logic [15:0]    n_reg;      // word count N
    logic [7:0]     lo_reg;     // lo byte of the word being assembled

    logic           accept;
    logic [15:0]    n_full;
    logic           last_word;

    assign accept = in_valid && in_ready_reg;

    // Header value as it completes, so LEN_HI can branch on it immediately.
    assign n_full = {in_data, n_lo_reg};

    // The write address doubles as the count of words already written, so the
    // last word is the one whose address equals N-1.
    assign last_word = (16'(wr_addr_reg) == (n_reg - 16'd1));

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                state_next = LEN_LO;
            end
            LEN_LO: begin
                if (accept) state_next = LEN_HI;
            end
            LEN_HI: begin
                if (accept) begin
                    if (n_full == 16'd0) begin
                        state_next = DONE;
                    end else if (17'(n_full) > (17'd1 << D)) begin
                        state_next = ERR;
                    end else begin
                        state_next = WORD_LO;
                    end
                end
            end
            WORD_LO: begin
                if (accept) state_next = WORD_HI;
            end
            WORD_HI: begin
                if (accept) state_next = WRITE;
            end
            WRITE: begin
                state_next = last_word ? DONE : WORD_LO;
            end
            DONE: begin
                state_next = DONE;
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and registered outputs. The outputs are decoded from state_next.
    // This lines them up with the state they describe, and does not cost a
    // cycle of latency.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            cpu_hold_reg  <= 1'b1;
            load_done_reg <= 1'b0;
            err_reg       <= 1'b0;
            n_lo_reg      <= '0;
            n_reg         <= '0;
            lo_reg        <= '0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= (state_next == LEN_LO)  || (state_next == LEN_HI) ||
                             (state_next == WORD_LO) || (state_next == WORD_HI);
            wr_en_reg     <= (state_next == WRITE);
            cpu_hold_reg  <= (state_next != DONE);
            load_done_reg <= (state_next == DONE);
            err_reg       <= (state_next == ERR);

            if (accept && (state_reg == LEN_LO)) n_lo_reg <= in_data;
            if (accept && (state_reg == LEN_HI)) n_reg    <= n_full;
            if (accept && (state_reg == WORD_LO)) lo_reg  <= in_data;

            // Hi byte bits 7:1 carry nothing; only bit 0 becomes word[8].
            if (accept && (state_reg == WORD_HI)) wr_data_reg <= {in_data[0], lo_reg};

            // Advance only when another word follows. This means a full
            // 2**D-word load ends at the top address without wrapping.
            if ((state_reg == WRITE) && !last_word) begin
                wr_addr_reg <= wr_addr_reg + {{(D-1){1'b0}}, 1'b1};
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign wr_en     = wr_en_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;
    assign cpu_hold  = cpu_hold_reg;
    assign load_done = load_done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_instr_loader.sv
// ----------------------------------------------------------------------------
// tb_instr_loader
//
// Self-checking bench for instr_loader. Byte streams are built in the bench.
// A reference model derives the expected RAM writes from the stream format:
// the header gives N, and word i lands at address i. The writes captured from
// the DUT are compared against that expected list, together with the status
// flags.
// ----------------------------------------------------------------------------
module tb_instr_loader;

    localparam int D = 10;
    localparam int W = 9;
    localparam int RAM_WORDS = 1 << D;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_ready;
    logic         wr_en;
    logic [D-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic         cpu_hold;
    logic         load_done;
    logic         err;

    instr_loader #(.D(D), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Captured write transactions and timing, sampled on the falling edge.
    int          got_addr[$];
    int          got_data[$];
    int          cyc = 0;
    int          last_wr_cyc = -1;
    int          first_done_cyc = -1;
    int          back_to_back = 0;
    logic        prev_wr = 1'b0;

    logic [7:0]  stream[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset && wr_en) begin
            got_addr.push_back(int'(wr_addr));
            got_data.push_back(int'(wr_data));
            last_wr_cyc = cyc;
            if (prev_wr) back_to_back = back_to_back + 1;
        end
        if (reset && load_done && first_done_cyc < 0) first_done_cyc = cyc;
        prev_wr = reset && wr_en;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " in_ready"},  32'(in_ready),  32'd0);
        check({tag, " wr_en"},     32'(wr_en),     32'd0);
        check({tag, " wr_addr"},   32'(wr_addr),   32'd0);
        check({tag, " wr_data"},   32'(wr_data),   32'd0);
        check({tag, " cpu_hold"},  32'(cpu_hold),  32'd1);
        check({tag, " load_done"}, 32'(load_done), 32'd0);
        check({tag, " err"},       32'(err),       32'd0);
    endtask

    // Reset applied at a falling edge and released two cycles later.
    task automatic do_reset(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_values(tag);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Offer one byte after a random idle gap. Must be called at a falling
    // edge, and returns at a falling edge after the accepting rising edge.
    task automatic send_byte(input logic [7:0] b, input int max_gap, output bit ok);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Send the global stream and compare the result against the model.
    task automatic run_stream(input string name, input int max_gap);
        int n;
        int n_bytes;
        int accepted;
        bit ok;
        bit exp_err;
        int exp_addr[$];
        int exp_data[$];

        // Reference model: the header gives N, and word i is written to
        // address i. A zero count finishes immediately, and a count larger
        // than the RAM is rejected.
        n = int'({stream[1], stream[0]});
        exp_err = (n > RAM_WORDS);
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(i);
                exp_data.push_back(int'(stream[3 + 2*i][0]) * 256 + int'(stream[2 + 2*i]));
            end
        end
        n_bytes = (exp_err || n == 0) ? 2 : 2 + 2*n;

        got_addr.delete();
        got_data.delete();
        last_wr_cyc = -1;
        first_done_cyc = -1;
        back_to_back = 0;

        @(negedge clk);
        accepted = 0;
        for (int i = 0; i < n_bytes; i++) begin
            send_byte(stream[i], max_gap, ok);
            if (!ok) break;
            accepted = accepted + 1;
        end
        check({name, " bytes_accepted"}, 32'(accepted), 32'(n_bytes));

        for (int i = 0; i < 20; i++) begin
            if (load_done || err) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);

        check({name, " load_done"}, 32'(load_done), exp_err ? 32'd0 : 32'd1);
        check({name, " err"},       32'(err),       exp_err ? 32'd1 : 32'd0);
        check({name, " cpu_hold"},  32'(cpu_hold),  exp_err ? 32'd1 : 32'd0);
        check({name, " in_ready"},  32'(in_ready),  32'd0);
        check({name, " wr_en_idle"}, 32'(wr_en),    32'd0);
        check({name, " num_writes"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        check({name, " back_to_back_wr"}, 32'(back_to_back), 32'd0);
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check($sformatf("%s addr[%0d]", name, i), 32'(got_addr[i]), 32'(exp_addr[i]));
            check($sformatf("%s data[%0d]", name, i), 32'(got_data[i]), 32'(exp_data[i]));
        end
        if (!exp_err && n > 0) begin
            check({name, " done_latency"}, 32'(first_done_cyc - last_wr_cyc), 32'd1);
        end
        $display("LOAD %s n=%0d writes=%0d load_done=%0d err=%0d cpu_hold=%0d",
                 name, n, got_addr.size(), load_done, err, cpu_hold);
    endtask

    task automatic build_test1();
        stream = '{8'h03, 8'h00, 8'h12, 8'h01, 8'h34, 8'h00, 8'hFF, 8'h01};
    endtask

    initial begin
        bit ok;
        int words;
        logic [8:0] w;

        // 1: basic three-word load
        do_reset("reset");
        build_test1();
        run_stream("t1", 0);

        // 2: empty program; extra bytes must be refused
        do_reset("reset2");
        stream = '{8'h00, 8'h00};
        run_stream("t2", 0);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2 extra in_ready[%0d]", i), 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("t2 extra writes", 32'(got_addr.size()), 32'd0);

        // 3: oversize header N=1025
        do_reset("reset3");
        stream = '{8'h01, 8'h04};
        run_stream("t3", 0);

        // 4: test 1 stream with random idle gaps
        do_reset("reset4");
        build_test1();
        run_stream("t4", 5);

        // 5: reset asserted after two of three words, then a clean reload
        do_reset("reset5");
        build_test1();
        got_addr.delete();
        got_data.delete();
        @(negedge clk);
        for (int i = 0; i < 6; i++) send_byte(stream[i], 2, ok);
        for (int i = 0; i < 20; i++) begin
            if (got_addr.size() >= 2) break;
            @(negedge clk);
        end
        check("t5 writes_before_reset", 32'(got_addr.size()), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("t5 async");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_stream("t5 reload", 0);

        // Randomized program of random length and content
        do_reset("reset_rand");
        words = int'($urandom_range(20, 1));
        stream = {};
        stream.push_back(8'(words));
        stream.push_back(8'(words >> 8));
        for (int i = 0; i < words; i++) begin
            w = 9'($urandom);
            stream.push_back(w[7:0]);
            stream.push_back({7'($urandom), w[8]});
        end
        run_stream("rand", 3);

        // 6: full RAM of incrementing words, hi-byte upper bits all set
        do_reset("reset6");
        stream = {};
        stream.push_back(8'h00);
        stream.push_back(8'h04);
        for (int i = 0; i < RAM_WORDS; i++) begin
            w = 9'(i);
            stream.push_back(w[7:0]);
            stream.push_back({7'h7F, w[8]});
        end
        run_stream("t6", 0);
        check("t6 final wr_addr", 32'(wr_addr), 32'h3FF);
        if (got_addr.size() > 0) begin
            check("t6 last write addr", 32'(got_addr[got_addr.size()-1]), 32'h3FF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
